// File: rtl/la_uart_cmd_ctrl_if.sv
// Signal bundle between the UART command front end and its surroundings:
// serial input and busy flag in, analyzer configuration and strobes out.
interface la_uart_cmd_ctrl_if;
  logic       uart_rx;
  logic       la_busy;
  logic       run_en;
  logic [1:0] trigger_mode;
  logic [7:0] trigger_mask;
  logic [7:0] edge_trigger;
  logic [7:0] trigger_type;
  logic       cfg_changed;
  logic       dump_req;
  logic       err_pulse;
  logic [2:0] err_code;

  modport master (
    output uart_rx, la_busy,
    input  run_en, trigger_mode, trigger_mask, edge_trigger, trigger_type,
    input  cfg_changed, dump_req, err_pulse, err_code
  );

  modport slave (
    input  uart_rx, la_busy,
    output run_en, trigger_mode, trigger_mask, edge_trigger, trigger_type,
    output cfg_changed, dump_req, err_pulse, err_code
  );
endinterface

// File: rtl/la_uart_cmd_ctrl.sv
// UART command receiver for the logic analyzer: 8N1 byte receiver plus a
// 4-byte frame parser (A5, CMD, ARG, CMD^ARG) that writes trigger/run controls.
module la_uart_cmd_ctrl #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  la_uart_cmd_ctrl_if.slave  cmd_if
);

  localparam int DIV  = CLK_FREQ / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int BCW  = $clog2(DIV + 1);
  localparam int TCW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [1:0] P_SYNC = 2'd0;
  localparam logic [1:0] P_CMD  = 2'd1;
  localparam logic [1:0] P_ARG  = 2'd2;
  localparam logic [1:0] P_CHK  = 2'd3;

  logic           r_rx_meta, r_rx_sync, r_rx_prev;
  logic [1:0]     r_rstate;
  logic [BCW-1:0] r_baud_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;

  logic [1:0]     r_pstate;
  logic [7:0]     r_cmd, r_arg;
  logic [TCW-1:0] r_tmo_cnt;

  logic           r_run_en;
  logic [1:0]     r_trigger_mode;
  logic [7:0]     r_trigger_mask, r_edge_trigger, r_trigger_type;
  logic           r_cfg_changed, r_dump_req, r_err_pulse;
  logic [2:0]     r_err_code;

  logic w_baud_done, w_half_done, w_byte_stb, w_byte_ok, w_frame_err, w_tmo_hit;
  logic [2:0] w_exec_err;

  assign w_baud_done = (r_baud_cnt == BCW'(DIV - 1));
  assign w_half_done = (r_baud_cnt == BCW'(HALF - 1));
  assign w_byte_stb  = (r_rstate == R_STOP) && w_baud_done;
  assign w_byte_ok   = w_byte_stb &&  r_rx_sync;
  assign w_frame_err = w_byte_stb && !r_rx_sync;
  assign w_tmo_hit   = (r_tmo_cnt == TCW'(TIMEOUT_CYCLES - 1));

  // Receiver: start re-checked mid-bit, then every bit sampled at its centre.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rstate   <= R_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_meta <= cmd_if.uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      case (r_rstate)
        R_IDLE: begin
          r_baud_cnt <= '0;
          if (r_rx_prev && !r_rx_sync) r_rstate <= R_START;
        end
        R_START: begin
          if (w_half_done) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_rstate   <= r_rx_sync ? R_IDLE : R_DATA;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_shift    <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx  <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_rstate <= R_STOP;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
        default: begin
          if (w_baud_done) begin
            r_baud_cnt <= '0;
            r_rstate   <= R_IDLE;
          end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame verdict; earlier checks mask later ones.
  always_comb begin
    w_exec_err = 3'd0;
    if (r_shift != (r_cmd ^ r_arg))
      w_exec_err = 3'd1;
    else if (r_cmd == 8'd0 || r_cmd > 8'd6)
      w_exec_err = 3'd2;
    else if (r_cmd == 8'd2 && r_arg > 8'd2)
      w_exec_err = 3'd3;
    else if (r_cmd >= 8'd2 && r_cmd <= 8'd5 && cmd_if.la_busy)
      w_exec_err = 3'd4;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pstate       <= P_SYNC;
      r_cmd          <= '0;
      r_arg          <= '0;
      r_tmo_cnt      <= '0;
      r_run_en       <= 1'b0;
      r_trigger_mode <= '0;
      r_trigger_mask <= '0;
      r_edge_trigger <= '0;
      r_trigger_type <= '0;
      r_cfg_changed  <= 1'b0;
      r_dump_req     <= 1'b0;
      r_err_pulse    <= 1'b0;
      r_err_code     <= '0;
    end else begin
      r_cfg_changed <= 1'b0;
      r_dump_req    <= 1'b0;
      r_err_pulse   <= 1'b0;
      if (w_frame_err) begin
        r_pstate    <= P_SYNC;
        r_tmo_cnt   <= '0;
        r_err_code  <= 3'd6;
        r_err_pulse <= 1'b1;
      end else if (w_byte_ok) begin
        r_tmo_cnt <= '0;
        case (r_pstate)
          P_SYNC: if (r_shift == 8'hA5) r_pstate <= P_CMD;
          P_CMD: begin
            r_cmd    <= r_shift;
            r_pstate <= P_ARG;
          end
          P_ARG: begin
            r_arg    <= r_shift;
            r_pstate <= P_CHK;
          end
          default: begin
            r_pstate <= P_SYNC;
            if (w_exec_err != 3'd0) begin
              r_err_code  <= w_exec_err;
              r_err_pulse <= 1'b1;
            end else begin
              r_err_code <= 3'd0;
              case (r_cmd)
                8'd1: r_run_en <= r_arg[0];
                8'd2: begin r_trigger_mode <= r_arg[1:0]; r_cfg_changed <= 1'b1; end
                8'd3: begin r_trigger_mask <= r_arg;      r_cfg_changed <= 1'b1; end
                8'd4: begin r_edge_trigger <= r_arg;      r_cfg_changed <= 1'b1; end
                8'd5: begin r_trigger_type <= r_arg;      r_cfg_changed <= 1'b1; end
                default: r_dump_req <= 1'b1;
              endcase
            end
          end
        endcase
      end else if (r_pstate != P_SYNC) begin
        if (w_tmo_hit) begin
          r_pstate    <= P_SYNC;
          r_tmo_cnt   <= '0;
          r_err_code  <= 3'd5;
          r_err_pulse <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end
    end
  end

  assign cmd_if.run_en       = r_run_en;
  assign cmd_if.trigger_mode = r_trigger_mode;
  assign cmd_if.trigger_mask = r_trigger_mask;
  assign cmd_if.edge_trigger = r_edge_trigger;
  assign cmd_if.trigger_type = r_trigger_type;
  assign cmd_if.cfg_changed  = r_cfg_changed;
  assign cmd_if.dump_req     = r_dump_req;
  assign cmd_if.err_pulse    = r_err_pulse;
  assign cmd_if.err_code     = r_err_code;

endmodule

// File: doc/la_uart_cmd_ctrl.md
# la_uart_cmd_ctrl

Remote-configuration front end for the logic analyzer. It receives framed command bytes on a UART RX pin, validates them, and drives the trigger-configuration and run/dump controls that feed the analyzer core. It sits upstream of the core, in parallel with the push-button configuration path. It replaces the per-channel cycling with direct register writes.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115200, UART bit rate. The bit divisor is DIV = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults).
- TIMEOUT_CYCLES, 5_000_000, maximum number of idle cycles allowed between bytes of one frame.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- uart_rx  in  1  asynchronous serial input, idle high.
- la_busy  in  1  high while the core is capturing; configuration writes are rejected while it is high.
- run_en  out  1  run/stop level.
- trigger_mode  out  2  trigger mode: 0=OR, 1=AND-ACC, 2=AND-COIN.
- trigger_mask  out  8  per-channel trigger enable.
- edge_trigger  out  8  per-channel trigger kind: 1=edge, 0=level.
- trigger_type  out  8  per-channel polarity: 0=rise/high, 1=fall/low.
- cfg_changed  out  1  single-cycle pulse on any update of mode, mask, edge or type.
- dump_req  out  1  single-cycle pulse requesting a UART re-dump.
- err_pulse  out  1  single-cycle pulse on any rejected byte or frame.
- err_code  out  3  code of the last error; cleared to 0 by the next accepted frame.

## Operation
- The RX path uses a 2-FF synchronizer on uart_rx.
- A start bit is detected on a synchronized 1->0 transition while the receiver is idle.
- The start bit is re-checked at DIV/2. If the line reads high at that point, the start is false and the receiver returns to idle with no error.
- Data bits are sampled every DIV cycles from that point, 8 bits, LSB first. The stop bit is sampled DIV cycles after bit 7.
- If the stop bit reads 0, the byte is discarded, the parser returns to P_SYNC, err_code=6 and err_pulse fires.
- Frame format is 4 bytes: 0xA5, CMD, ARG, CHK, where CHK = CMD ^ ARG.
- Parser states and transitions:
  - P_SYNC: any byte other than 0xA5 is ignored silently; 0xA5 moves to P_CMD.
  - P_CMD captures CMD and moves to P_ARG.
  - P_ARG captures ARG and moves to P_CHK.
  - P_CHK checks and executes the frame, then always returns to P_SYNC.
- Commands:
  - 0x01 RUN: run_en <= ARG[0].
  - 0x02 MODE: ARG must be <= 2, otherwise err 3. Sets trigger_mode.
  - 0x03 MASK: writes trigger_mask.
  - 0x04 EDGE: writes edge_trigger.
  - 0x05 TYPE: writes trigger_type.
  - 0x06 DUMP: pulses dump_req.
  - Any other CMD: err 2.
- Error check priority: checksum mismatch (err 1) first, then unknown CMD (err 2), then bad ARG (err 3), then busy reject (err 4).
- Busy reject (err 4) applies to commands 0x02-0x05 when la_busy=1. RUN and DUMP are always accepted.
- Timeout: in P_CMD, P_ARG or P_CHK, TIMEOUT_CYCLES cycles without a completed byte sends the parser to P_SYNC with err 5. The timeout counter resets on every completed byte.
- On any error, the configuration outputs are left unchanged.

## Timing
- Reset values: run_en=0, trigger_mode=0, trigger_mask=0, edge_trigger=0, trigger_type=0, cfg_changed=0, dump_req=0, err_pulse=0, err_code=0. The parser resets to P_SYNC and the RX path to idle.
- The internal byte-valid strobe fires in the cycle of the stop-bit sample (cycle N).
- For the CHK byte, register writes and the cfg_changed, dump_req and err_pulse strobes are all visible at N+1.
- A MASK/EDGE/TYPE/MODE write pulses cfg_changed even if the written value equals the current value.
- la_busy is sampled at cycle N.
- A new start bit may be detected in the cycle after the stop-bit sample, so back-to-back frames are supported.
- Reset mid-frame: all state clears immediately and the partial frame is lost.
- Latency from the start-bit falling edge of the CHK byte to the output update is about 9.5·DIV + 3 cycles, including the synchronizer.

## Test plan
- Frame A5 03 0F 0C with la_busy=0 -> trigger_mask=0x0F, one cfg_changed pulse, err_code=0.
- Frame A5 02 03 01 -> err_code=3, one err_pulse, trigger_mode unchanged.
- Frame A5 04 FF 00 (bad CHK) -> err_code=1. A following valid frame A5 04 FF FB sets edge_trigger=0xFF and clears err_code to 0.
- With la_busy=1: frame A5 05 AA AF -> err_code=4 and trigger_type unchanged. Frame A5 01 01 00 in the same condition -> run_en=1.
- Send A5 06 and then stay idle for TIMEOUT_CYCLES -> err_code=5. A subsequent A5 06 00 06 -> one dump_req pulse.
- Byte with stop bit forced low -> err_code=6. Assert sys_rst_n low mid-frame -> all outputs return to their reset values.
